// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for ram_stream_reader: default widths and FSM state encoding.
package ram_stream_reader_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 12;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_READ  = 3'd1;
    localparam logic [STATE_W-1:0] S_OUT   = 3'd2;
    localparam logic [STATE_W-1:0] S_CLEAR = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

endpackage

// File: rtl/ram_stream_reader_ctr.sv
// Loadable down-counter of words still to be streamed; `last` marks one word left.
module ram_stream_reader_ctr #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] value,
    output logic             last
);

    logic [WIDTH-1:0] count;

    // Load on an accepted start, count down once per consumed word.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (dec)
            count <= count - 1'b1;
    end

    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/ram_stream_reader.sv
// Drains a contiguous RAM block onto a valid/ready stream, one word at a time.
// Build option RAM_STREAM_READER_CLEAR_EN: zero each RAM word after it is
// consumed (mailbox semantics), adding one CLEAR cycle per word.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH-1:0] length,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [STATE_W-1:0] state, state_next;
    logic accept, handshake, dec, last, advance;

    assign accept    = (state == S_IDLE) && start;
    assign handshake = (state == S_OUT) && out_valid && out_ready;

    // The word count drops as the word is finished with: at the handshake
    // normally, or at the end of its CLEAR cycle when clearing is built in,
    // so `last` always describes the word currently being retired.
`ifdef RAM_STREAM_READER_CLEAR_EN
    assign dec = (state == S_CLEAR);
`else
    assign dec = handshake;
`endif
    assign advance = dec && !last;

    ram_stream_reader_ctr #(
        .WIDTH (ADDRESS_WIDTH)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .dec   (dec),
        .value (length),
        .last  (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (length == '0) ? S_DONE : S_READ;
            S_READ:  state_next = S_OUT;
`ifdef RAM_STREAM_READER_CLEAR_EN
            S_OUT:   if (handshake) state_next = S_CLEAR;
            S_CLEAR: state_next = last ? S_DONE : S_READ;
`else
            S_OUT:   if (handshake) state_next = last ? S_DONE : S_READ;
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; write data is always zero (only clears are written).
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        mem_dataIn = '0;
`ifdef RAM_STREAM_READER_CLEAR_EN
        mem_wEn    = (state == S_CLEAR);
`else
        mem_wEn    = 1'b0;
`endif
    end

    // Address and stream registers; RAM data is valid on the edge leaving READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept)
                mem_addr <= base_addr;
            else if (advance)
                mem_addr <= mem_addr + 1'b1;
            if (state == S_READ) begin
                out_data  <= mem_dataOut;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized self-checking bench for ram_stream_reader with a behavioural RAM.
// Honours RAM_STREAM_READER_CLEAR_EN when built with it.
module tb_ram_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int RAM_N = 4096;
`ifdef RAM_STREAM_READER_CLEAR_EN
    localparam int WORD_CYC = 3;
    localparam int DONE_LAG = 2;
    localparam bit CLR      = 1'b1;
`else
    localparam int WORD_CYC = 2;
    localparam int DONE_LAG = 1;
    localparam bit CLR      = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic [AW-1:0] base_addr, length;
    logic          busy, done, mem_wEn, out_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dataIn, mem_dataOut, out_data;

    always #5 clk = ~clk;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .mem_wEn     (mem_wEn),
        .mem_addr    (mem_addr),
        .mem_dataIn  (mem_dataIn),
        .mem_dataOut (mem_dataOut),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    // Behavioural RAM: write on rising edge, read data updated on falling edge.
    logic [DW-1:0] ram [RAM_N];
    logic          fill_en;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;

    always @(posedge clk) begin
        if (fill_en)      ram[fill_addr] <= fill_data;
        else if (mem_wEn) ram[mem_addr]  <= mem_dataIn;
    end

    always @(negedge clk) mem_dataOut <= ram[mem_addr];

    // Reference contents the RAM should hold.
    logic [DW-1:0] model [RAM_N];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write n words starting at base: v0, v0+1, ... or random values.
    task automatic fill(input int base, input int n, input logic [DW-1:0] v0, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i) % RAM_N;
            @(negedge clk);
            fill_en   = 1'b1;
            fill_addr = AW'(a);
            fill_data = rnd ? DW'($urandom) : v0 + DW'(i);
            model[a]  = fill_data;
        end
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    // One transfer; words expected are model[base .. base+len-1] modulo RAM size.
    task automatic run_xfer(input string nm, input int base, input int len,
                            input int stall_pct, input int stall_word, input int stall_len);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] prev_d;
        int got, cyc, stall_cnt, last_hs, done_cyc, first_v, wen_cnt;
        int stab_bad, busy_bad, space_bad, din_bad, wen_bad;
        bit prev_v, prev_hs, rdy, hs;
        got = 0; cyc = 0; stall_cnt = 0; last_hs = -1; done_cyc = -1; first_v = -1;
        wen_cnt = 0; stab_bad = 0; busy_bad = 0; space_bad = 0; din_bad = 0; wen_bad = 0;
        prev_v = 0; prev_hs = 0; prev_d = '0;
        for (int i = 0; i < len; i++) exp_q.push_back(model[(base + i) % RAM_N]);

        @(negedge clk);
        start = 1'b1; base_addr = AW'(base); length = AW'(len); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({nm, ":addr_after_start"}, 64'(mem_addr), 64'(base % RAM_N));
        chk({nm, ":busy_after_start"}, 64'(busy), 64'(1));

        while (done_cyc < 0 && cyc < 400) begin
            if (mem_dataIn != '0) din_bad++;
            if (mem_wEn) wen_cnt++;
            if (mem_wEn != (CLR && prev_hs)) wen_bad++;
            if (!busy) busy_bad++;
            if (done) begin
                done_cyc  = cyc;
                start     = 1'b0;
                out_ready = 1'b0;
            end else begin
                if (out_valid && first_v < 0) first_v = cyc;
                if (prev_v && !prev_hs && (!out_valid || out_data !== prev_d)) stab_bad++;
                if (got == stall_word && stall_cnt < stall_len) rdy = 1'b0;
                else rdy = ($urandom_range(99) >= stall_pct);
                if (out_valid && got == stall_word && !rdy) stall_cnt++;
                out_ready = rdy;
                // Spurious start requests while busy must be ignored.
                if ($urandom_range(3) == 0) begin
                    start = 1'b1; base_addr = AW'($urandom); length = AW'($urandom);
                end else begin
                    start = 1'b0;
                end
                hs = out_valid && rdy;
                if (hs) begin
                    if (got < len) chk({nm, ":data"}, 64'(out_data), 64'(exp_q[got]));
                    else           chk({nm, ":extra_word"}, 64'(got), 64'(len));
                    chk({nm, ":addr_at_hs"}, 64'(mem_addr), 64'((base + got) % RAM_N));
                    if (last_hs >= 0 && stall_pct == 0 && stall_len == 0 && cyc - last_hs != WORD_CYC)
                        space_bad++;
                    last_hs = cyc;
                    got++;
                end
                prev_hs = hs; prev_v = out_valid; prev_d = out_data;
            end
            cyc++;
            @(negedge clk);
        end

        chk({nm, ":done_seen"}, 64'(done_cyc >= 0), 64'(1));
        chk({nm, ":word_count"}, 64'(got), 64'(len));
        if (len == 0) begin
            chk({nm, ":len0_done_cyc"}, 64'(done_cyc), 64'(0));
            chk({nm, ":len0_no_valid"}, 64'(first_v), 64'(-1));
        end else begin
            chk({nm, ":first_valid_cyc"}, 64'(first_v), 64'(1));
            chk({nm, ":done_lag"}, 64'(done_cyc - last_hs), 64'(DONE_LAG));
        end
        chk({nm, ":stable_hold"}, 64'(stab_bad), 64'(0));
        chk({nm, ":busy_through"}, 64'(busy_bad), 64'(0));
        chk({nm, ":throughput"}, 64'(space_bad), 64'(0));
        chk({nm, ":dataIn_zero"}, 64'(din_bad), 64'(0));
        chk({nm, ":wEn_timing"}, 64'(wen_bad), 64'(0));
        chk({nm, ":wEn_count"}, 64'(wen_cnt), 64'(CLR ? len : 0));
        chk({nm, ":idle_busy"}, 64'(busy), 64'(0));
        chk({nm, ":idle_done"}, 64'(done), 64'(0));
        if (CLR) for (int i = 0; i < len; i++) model[(base + i) % RAM_N] = '0;
        for (int i = 0; i < len; i++)
            chk({nm, ":ram_after"}, 64'(ram[(base + i) % RAM_N]), 64'(model[(base + i) % RAM_N]));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ":busy"},      64'(busy),       64'(0));
        chk({nm, ":done"},      64'(done),       64'(0));
        chk({nm, ":wEn"},       64'(mem_wEn),    64'(0));
        chk({nm, ":addr"},      64'(mem_addr),   64'(0));
        chk({nm, ":dataIn"},    64'(mem_dataIn), 64'(0));
        chk({nm, ":out_data"},  64'(out_data),   64'(0));
        chk({nm, ":out_valid"}, 64'(out_valid),  64'(0));
    endtask

    // Reset while the second of four words is waiting in OUT.
    task automatic reset_mid();
        int got, n, dn;
        bit hit;
        got = 0; hit = 0; dn = 0;
        fill(200, 4, 32'd11, 1'b0);
        @(negedge clk);
        start = 1'b1; base_addr = AW'(200); length = AW'(4); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!hit && n < 20) begin
            if (out_valid && got == 0) begin
                chk("rstmid:word1", 64'(out_data), 64'(11));
                out_ready = 1'b1; got = 1;
            end else if (out_valid && got == 1) begin
                out_ready = 1'b0; hit = 1'b1;
            end else begin
                out_ready = 1'b0;
            end
            n++;
            if (!hit) @(negedge clk);
        end
        chk("rstmid:reached_word2", 64'(hit), 64'(1));
        chk("rstmid:word2_pending", 64'(out_data), 64'(12));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("rstmid");
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("rstmid:no_done_after", 64'(dn), 64'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        fill_en = 1'b0; fill_addr = '0; fill_data = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        fill(100, 4, 32'd1, 1'b0);
        run_xfer("seq", 100, 4, 0, -1, 0);

        fill(100, 4, 32'd1, 1'b0);
        run_xfer("stall", 100, 4, 0, 1, 5);

        run_xfer("len0", 300, 0, 0, -1, 0);

        fill(4094, 4, 32'hA, 1'b0);
        run_xfer("wrap", 4094, 4, 0, -1, 0);

        reset_mid();
        fill(100, 4, 32'd1, 1'b0);
        run_xfer("after_rst", 100, 4, 0, -1, 0);

        fill(54, 2, 32'd0, 1'b1);
        run_xfer("mbox", 54, 2, 0, -1, 0);

        for (int t = 0; t < 8; t++) begin
            int b, l;
            b = $urandom_range(RAM_N - 1);
            l = $urandom_range(6, 1);
            fill(b, l, 32'd0, 1'b1);
            run_xfer("rand", b, l, $urandom_range(60), -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
